noise_injector: RTL and testbench
=================================

# noise_injector

Stereo sample datapath for the audio loopback path, driven by the read/noise/write enables from the pipeline control unit. It captures a left/right sample pair on `read_ena` and, on `noise_ena`, adds scaled pseudo-random noise with saturation. On `write_ena` it presents the result to the codec write port as a registered sample pair with a one-cycle valid strobe.

## Interface
- `DATA_W`, 24: sample width, two's complement.
- `NOISE_W`, 8: raw noise draw width per channel, signed.
- `LFSR_SEED`, 32'h0000_0001: LFSR reset value; must be nonzero.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `read_ena`  in  1  capture `left_in`/`right_in`.
- `noise_ena`  in  1  add noise to the held pair.
- `write_ena`  in  1  transfer the held pair to the outputs.
- `noise_gain`  in  2  noise scale: 0 = off; g = 1..3 shifts noise left by 4·(g−1).
- `left_in`, `right_in`  in  DATA_W  codec read samples.
- `left_out`, `right_out`  out  DATA_W  registered output samples.
- `out_valid`  out  1  one-cycle strobe when the outputs update.
- `sat_flag`  out  1  saturation occurred in the sample being presented; meaningful only with `out_valid`.
- `seq_err`  out  1  one-cycle strobe on an illegal enable sequence.

## Operation
- States: EMPTY, RAW, DONE.
  - RAW: pair held, no noise added.
  - DONE: noise added.
  - Per-channel sat bits are held alongside the pair.
- `read_ena`, in any state:
  - Load the hold registers from the inputs.
  - Clear the held sat bits.
  - Go to RAW.
- `noise_ena` in RAW:
  - Left noise = sext(lfsr[NOISE_W-1:0]); right noise = sext(lfsr[31:32-NOISE_W]).
  - Each noise value is scaled per `noise_gain` and added to the held sample in DATA_W+1 bits.
  - Result clamps to 2^(DATA_W-1)−1 or −2^(DATA_W-1); set that channel's sat bit when clamped.
  - Step the LFSR once; go to DONE.
- `noise_ena` in EMPTY or DONE: no data change, no LFSR step, `seq_err` pulse.
- `write_ena` in RAW or DONE:
  - Outputs ← hold registers; `sat_flag` ← OR of the held sat bits; `out_valid` pulse.
  - Go to EMPTY.
- `write_ena` in EMPTY: outputs unchanged, no `out_valid`, `seq_err` pulse.
- Simultaneous `read_ena` and `write_ena`:
  - The write transfers the old held pair.
  - The read loads the new pair; next state is RAW.
  - If the state was EMPTY, the write half is an error: `seq_err` pulses, and the read still loads.
- `noise_ena` with any other enable in the same cycle: the noise is ignored and `seq_err` pulses; the other enables act normally.
- LFSR: Galois, right-shift. next = (lfsr >> 1) ^ (lfsr[0] ? 32'h8020_0003 : 0), i.e. x^32+x^22+x^2+x+1. It steps only on an accepted noise.
- Gain 0: the noise add still occurs with noise = 0 and the LFSR still steps.

## Timing
- All outputs are registered. Reset values:
  - `left_out` = 0, `right_out` = 0.
  - `out_valid` = 0, `sat_flag` = 0, `seq_err` = 0.
  - State EMPTY, hold registers 0, LFSR = `LFSR_SEED`.
- Enables are sampled on the rising edge.
- `out_valid` and the new outputs appear the cycle after `write_ena` is sampled. Outputs then hold until the next accepted write.
- `seq_err` is high for the cycle after the offending enable.
- Noise result is ready one cycle after `noise_ena`, which matches the control unit's NOISEADD→WAITFORWRITE spacing.
- Reset mid-operation clears everything immediately. The pending sample is discarded, with no `out_valid`, and the LFSR is reseeded.
- Back-to-back samples are accepted every cycle; there is no internal stall.

## Structure
- Package `noise_pkg`:
  - state enum (EMPTY/RAW/DONE);
  - LFSR tap mask 32'h8020_0003;
  - default seed;
  - gain shift-step constant (4).
- Sub-module `noise_lfsr`: 32-bit Galois LFSR with seed parameter, step enable and async active-low reset. Top level holds the FSM, the scale, the saturating adders and the output registers.

## Test plan
- Reset, then passthrough with gain 0: L = 24'h123456, R = 24'hFEDCBA; read, noise, write. Required next cycle: `left_out` = 24'h123456, `right_out` = 24'hFEDCBA, `out_valid` = 1 for one cycle, `sat_flag` = 0.
- Seeded noise with gain 1 after reset:
  - Sample 1: L = 100, R = 0 → L = 101, R = 0.
  - Sample 2: L = 0, R = 0 → L = 3, R = 24'hFFFF80.
- Saturation with gain 3 after reset:
  - Sample 1: L = 24'h7FFF80 → 24'h7FFFFF, `sat_flag` = 1.
  - Sample 2: R = 24'h800100 → 24'h800000, `sat_flag` = 1.
- Sequencing errors after reset:
  - `noise_ena` alone → `seq_err` pulse and no LFSR step; the next valid gain-1 draw still gives left +1.
  - `write_ena` in EMPTY → `seq_err` pulse, `out_valid` = 0, outputs unchanged.
- Write from RAW with no noise: read L = 24'h000555, then write → `left_out` = 24'h000555. Simultaneous read+write delivers the old pair, and the new pair follows on the next write.
- Async reset between noise and write → outputs 0 immediately, no `out_valid` after release, and the LFSR restarts at the seed (next left noise +1).

Source files
------------

// File: rtl/noise_pkg.sv
// noise_pkg: shared state encoding and constants for the noise injector datapath
package noise_pkg;
  typedef enum logic [1:0] {EMPTY, RAW, DONE} state_t;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEF = 32'h0000_0001;
  localparam int GAIN_STEP = 4;
endpackage

// File: rtl/noise_lfsr.sv
// noise_lfsr: 32-bit right-shifting Galois LFSR, advances only when step is high
module noise_lfsr
  import noise_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  output logic [31:0] lfsr
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) lfsr <= SEED;
    else if (step) lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
endmodule

// File: rtl/noise_injector.sv
// noise_injector: stereo hold/noise/write datapath with saturating scaled LFSR noise
module noise_injector
  import noise_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int NOISE_W = 8,
  parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_ena,
  input  logic              noise_ena,
  input  logic              write_ena,
  input  logic [1:0]        noise_gain,
  input  logic [DATA_W-1:0] left_in,
  input  logic [DATA_W-1:0] right_in,
  output logic [DATA_W-1:0] left_out,
  output logic [DATA_W-1:0] right_out,
  output logic              out_valid,
  output logic              sat_flag,
  output logic              seq_err
);
  state_t state;
  logic [DATA_W-1:0] hold_l, hold_r;
  logic sat_l, sat_r;
  logic [31:0] lfsr;
  logic [3:0] shift;
  logic noise_ok, noise_err, write_ok, write_err;
  logic [DATA_W:0] add_l, add_r;
  // Returns {clamped, result}: sample plus scaled noise in DATA_W+1 bits, clamped on overflow
  function automatic logic [DATA_W:0] sat_add(input logic [DATA_W-1:0] s, input logic [NOISE_W-1:0] n,
                                               input logic off, input logic [3:0] sh);
    logic [DATA_W:0] nx, sum;
    nx = off ? '0 : {{(DATA_W+1-NOISE_W){n[NOISE_W-1]}}, n} << sh;
    sum = {s[DATA_W-1], s} + nx;
    return (sum[DATA_W] != sum[DATA_W-1]) ? {1'b1, sum[DATA_W], {(DATA_W-1){~sum[DATA_W]}}}
                                          : {1'b0, sum[DATA_W-1:0]};
  endfunction
  always_comb begin
    shift = 4'(GAIN_STEP) * {2'b00, noise_gain - 2'd1};
    noise_ok = noise_ena && !read_ena && !write_ena && state == RAW;
    noise_err = noise_ena && !noise_ok;
    write_ok = write_ena && state != EMPTY;
    write_err = write_ena && state == EMPTY;
    add_l = sat_add(hold_l, lfsr[NOISE_W-1:0], noise_gain == 2'd0, shift);
    add_r = sat_add(hold_r, lfsr[31:32-NOISE_W], noise_gain == 2'd0, shift);
  end
  noise_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk(clk),
    .reset(reset),
    .step(noise_ok),
    .lfsr(lfsr)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= EMPTY;
      hold_l <= '0;
      hold_r <= '0;
      sat_l <= 1'b0;
      sat_r <= 1'b0;
      left_out <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
      sat_flag <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      out_valid <= write_ok;
      seq_err <= noise_err || write_err;
      if (write_ok) begin
        left_out <= hold_l;
        right_out <= hold_r;
        sat_flag <= sat_l | sat_r;
      end
      if (read_ena) begin
        hold_l <= left_in;
        hold_r <= right_in;
        sat_l <= 1'b0;
        sat_r <= 1'b0;
        state <= RAW;
      end else if (write_ok) begin
        state <= EMPTY;
      end else if (noise_ok) begin
        hold_l <= add_l[DATA_W-1:0];
        hold_r <= add_r[DATA_W-1:0];
        sat_l <= add_l[DATA_W];
        sat_r <= add_r[DATA_W];
        state <= DONE;
      end
    end
endmodule

// File: tb/tb_noise_injector.sv
// tb_noise_injector: directed vectors with hand-computed results for noise_injector
module tb_noise_injector;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic read_ena = 1'b0, noise_ena = 1'b0, write_ena = 1'b0;
  logic [1:0] noise_gain = 2'd0;
  logic [23:0] left_in = '0, right_in = '0;
  logic [23:0] left_out, right_out;
  logic out_valid, sat_flag, seq_err;
  int tests = 0, fails = 0;

  noise_injector dut (
    .clk(clk),
    .reset(reset),
    .read_ena(read_ena),
    .noise_ena(noise_ena),
    .write_ena(write_ena),
    .noise_gain(noise_gain),
    .left_in(left_in),
    .right_in(right_in),
    .left_out(left_out),
    .right_out(right_out),
    .out_valid(out_valid),
    .sat_flag(sat_flag),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic n, input logic w);
    read_ena = r;
    noise_ena = n;
    write_ena = w;
    @(posedge clk);
    #1;
    read_ena = 1'b0;
    noise_ena = 1'b0;
    write_ena = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic sample(input logic [23:0] l, input logic [23:0] r, input logic add);
    left_in = l;
    right_in = r;
    cyc(1, 0, 0);
    if (add) cyc(0, 1, 0);
    cyc(0, 0, 1);
  endtask

  initial begin
    do_reset();
    check("rst_left", left_out, 0);
    check("rst_right", right_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_seq", seq_err, 0);

    noise_gain = 2'd0;
    sample(24'h123456, 24'hFEDCBA, 1);
    check("pass_left", left_out, 24'h123456);
    check("pass_right", right_out, 24'hFEDCBA);
    check("pass_valid", out_valid, 1);
    check("pass_sat", sat_flag, 0);
    cyc(0, 0, 0);
    check("pass_valid_drop", out_valid, 0);
    check("pass_hold", left_out, 24'h123456);

    do_reset();
    noise_gain = 2'd1;
    sample(24'd100, 24'd0, 1);
    check("g1_s1_left", left_out, 24'd101);
    check("g1_s1_right", right_out, 24'd0);
    sample(24'd0, 24'd0, 1);
    check("g1_s2_left", left_out, 24'd3);
    check("g1_s2_right", right_out, 24'hFFFF80);
    check("g1_s2_sat", sat_flag, 0);

    do_reset();
    noise_gain = 2'd3;
    sample(24'h7FFF80, 24'd0, 1);
    check("g3_s1_left", left_out, 24'h7FFFFF);
    check("g3_s1_right", right_out, 24'd0);
    check("g3_s1_sat", sat_flag, 1);
    sample(24'd0, 24'h800100, 1);
    check("g3_s2_left", left_out, 24'h000300);
    check("g3_s2_right", right_out, 24'h800000);
    check("g3_s2_sat", sat_flag, 1);

    do_reset();
    noise_gain = 2'd1;
    cyc(0, 1, 0);
    check("noise_empty_seq", seq_err, 1);
    check("noise_empty_valid", out_valid, 0);
    cyc(0, 0, 0);
    check("seq_drop", seq_err, 0);
    sample(24'd0, 24'd0, 1);
    check("no_step_left", left_out, 24'd1);
    cyc(0, 0, 1);
    check("wr_empty_seq", seq_err, 1);
    check("wr_empty_valid", out_valid, 0);
    check("wr_empty_hold", left_out, 24'd1);

    sample(24'h000555, 24'h000AAA, 0);
    check("raw_left", left_out, 24'h000555);
    check("raw_right", right_out, 24'h000AAA);
    left_in = 24'h000111;
    right_in = 24'h000222;
    cyc(1, 0, 0);
    left_in = 24'h000333;
    right_in = 24'h000444;
    cyc(1, 0, 1);
    check("rw_left_old", left_out, 24'h000111);
    check("rw_right_old", right_out, 24'h000222);
    check("rw_valid", out_valid, 1);
    check("rw_seq", seq_err, 0);
    cyc(0, 0, 1);
    check("rw_left_new", left_out, 24'h000333);
    check("rw_right_new", right_out, 24'h000444);

    left_in = 24'd0;
    right_in = 24'd0;
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    #2 reset = 1'b0;
    #1;
    check("arst_left", left_out, 0);
    check("arst_right", right_out, 0);
    check("arst_valid", out_valid, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    cyc(0, 0, 0);
    check("arst_no_valid", out_valid, 0);
    sample(24'd0, 24'd0, 1);
    check("arst_reseed", left_out, 24'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
